ct_vfalu_pipe6_sched: RTL and testbench

//  Issue scheduler for vfalu pipe6 (fadd + fspu datapath). Arbitrates two requesters (req0 = vector

---
 rtl/ct_vfalu_pipe6_pkg.sv | 19 +
 rtl/ct_vfalu_pipe6_rr_arb.sv | 33 +++
 rtl/ct_vfalu_pipe6_sched.sv | 118 +++++++++++
 tb/tb_ct_vfalu_pipe6_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_vfalu_pipe6_pkg.sv
// Shared types and constants for the vfalu pipe6 issue scheduler.
package ct_vfalu_pipe6_pkg;

  localparam int unsigned TAG_W_DEF  = 7;
  localparam int unsigned FUNC_W_DEF = 20;

  localparam logic [2:0] SEL_IDLE = 3'b000;
  localparam logic [2:0] SEL_FADD = 3'b001;
  localparam logic [2:0] SEL_FSPU = 3'b010;

  typedef struct packed {
    logic                 vld;
    logic                 owner;
    logic                 mfvr;
    logic                 ereg;
    logic [TAG_W_DEF-1:0] tag;
  } stage_t;

endpackage

// File: rtl/ct_vfalu_pipe6_rr_arb.sv
// Two-way round-robin arbiter with per-request eligibility; pointer names the preferred requester.
module ct_vfalu_pipe6_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = elig;
    ptr_d = ptr_q;
    if (&elig) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ct_vfalu_pipe6_sched.sv
// vfalu pipe6 issue scheduler: round-robin issue into ex1, ex1..ex3 tracking, writeback valids/tags.
module ct_vfalu_pipe6_sched
  import ct_vfalu_pipe6_pkg::*;
#(
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned FUNC_W = FUNC_W_DEF
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              rtu_yy_xx_flush,
  input  logic              req0_vld,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic [2:0]        req0_sel,
  input  logic [TAG_W-1:0]  req0_dst_tag,
  input  logic              req0_mfvr,
  input  logic              req0_ereg,
  output logic              req0_rdy,
  input  logic              req1_vld,
  input  logic [FUNC_W-1:0] req1_func,
  input  logic [2:0]        req1_sel,
  input  logic [TAG_W-1:0]  req1_dst_tag,
  input  logic              req1_mfvr,
  input  logic              req1_ereg,
  output logic              req1_rdy,
  input  logic              ext_wb_resv_3,
  output logic [FUNC_W-1:0] dp_vfalu_ex1_pipex_func,
  output logic [2:0]        dp_vfalu_ex1_pipex_sel,
  output logic              ex1_vld,
  output logic              ex1_owner,
  output logic              mfvr_wb_vld,
  output logic [TAG_W-1:0]  mfvr_wb_tag,
  output logic              ex3_freg_wb_vld,
  output logic [TAG_W-1:0]  ex3_freg_wb_tag,
  output logic              ex3_ereg_wb_vld,
  output logic              ex3_owner,
  output logic              pipe_busy
);

  logic [1:0]        elig;
  logic [1:0]        gnt;
  stage_t            ex1_q, ex1_d;
  stage_t            ex2_q, ex2_d;
  stage_t            ex3_q, ex3_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [2:0]        sel_q, sel_d;

  // A reserved ex3 freg port only blocks ops that would write it; mfvr ops never do.
  always_comb begin
    elig[0] = req0_vld & ~rtu_yy_xx_flush & ~cpurst & (req0_mfvr | ~ext_wb_resv_3);
    elig[1] = req1_vld & ~rtu_yy_xx_flush & ~cpurst & (req1_mfvr | ~ext_wb_resv_3);
  end

  ct_vfalu_pipe6_rr_arb u_arb (
    .clk  (forever_cpuclk),
    .rst  (cpurst),
    .elig (elig),
    .gnt  (gnt)
  );

  always_comb begin
    ex1_d  = '0;
    sel_d  = SEL_IDLE;
    func_d = func_q;
    if (gnt[0]) begin
      ex1_d.vld   = 1'b1;
      ex1_d.owner = 1'b0;
      ex1_d.mfvr  = req0_mfvr;
      ex1_d.ereg  = req0_ereg;
      ex1_d.tag   = TAG_W_DEF'(req0_dst_tag);
      sel_d       = req0_sel;
      func_d      = req0_func;
    end else if (gnt[1]) begin
      ex1_d.vld   = 1'b1;
      ex1_d.owner = 1'b1;
      ex1_d.mfvr  = req1_mfvr;
      ex1_d.ereg  = req1_ereg;
      ex1_d.tag   = TAG_W_DEF'(req1_dst_tag);
      sel_d       = req1_sel;
      func_d      = req1_func;
    end
    // Records are zeroed rather than just invalidated so idle outputs read as 0.
    ex2_d = (ex1_q.vld & ~rtu_yy_xx_flush) ? ex1_q : '0;
    ex3_d = (ex2_q.vld & ~rtu_yy_xx_flush) ? ex2_q : '0;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      ex1_q  <= '0;
      ex2_q  <= '0;
      ex3_q  <= '0;
      func_q <= '0;
      sel_q  <= SEL_IDLE;
    end else begin
      ex1_q  <= ex1_d;
      ex2_q  <= ex2_d;
      ex3_q  <= ex3_d;
      func_q <= func_d;
      sel_q  <= sel_d;
    end
  end

  always_comb begin
    req0_rdy                = gnt[0];
    req1_rdy                = gnt[1];
    dp_vfalu_ex1_pipex_func = func_q;
    dp_vfalu_ex1_pipex_sel  = sel_q;
    ex1_vld                 = ex1_q.vld;
    ex1_owner               = ex1_q.owner;
    mfvr_wb_vld             = ex1_q.vld & ex1_q.mfvr;
    mfvr_wb_tag             = mfvr_wb_vld ? TAG_W'(ex1_q.tag) : '0;
    ex3_freg_wb_vld         = ex3_q.vld & ~ex3_q.mfvr;
    ex3_freg_wb_tag         = ex3_freg_wb_vld ? TAG_W'(ex3_q.tag) : '0;
    ex3_ereg_wb_vld         = ex3_q.vld & ex3_q.ereg;
    ex3_owner               = ex3_q.owner;
    pipe_busy               = ex1_q.vld | ex2_q.vld | ex3_q.vld;
  end

endmodule

// File: tb/tb_ct_vfalu_pipe6_sched.sv
// Self-checking bench for ct_vfalu_pipe6_sched: directed scenarios then random traffic vs a cycle-history model.
module tb_ct_vfalu_pipe6_sched;

  localparam int unsigned TAG_W  = 7;
  localparam int unsigned FUNC_W = 20;
  localparam int NRAND = 1500;

  logic              clk;
  logic              cpurst;
  logic              flush;
  logic              req0_vld, req1_vld;
  logic [FUNC_W-1:0] req0_func, req1_func;
  logic [2:0]        req0_sel, req1_sel;
  logic [TAG_W-1:0]  req0_dst_tag, req1_dst_tag;
  logic              req0_mfvr, req1_mfvr;
  logic              req0_ereg, req1_ereg;
  logic              req0_rdy, req1_rdy;
  logic              resv;
  logic [FUNC_W-1:0] func_o;
  logic [2:0]        sel_o;
  logic              ex1_vld, ex1_owner;
  logic              mfvr_wb_vld;
  logic [TAG_W-1:0]  mfvr_wb_tag;
  logic              ex3_freg_wb_vld;
  logic [TAG_W-1:0]  ex3_freg_wb_tag;
  logic              ex3_ereg_wb_vld;
  logic              ex3_owner;
  logic              pipe_busy;

  ct_vfalu_pipe6_sched #(.TAG_W(TAG_W), .FUNC_W(FUNC_W)) dut (
    .forever_cpuclk          (clk),
    .cpurst                  (cpurst),
    .rtu_yy_xx_flush         (flush),
    .req0_vld                (req0_vld),
    .req0_func               (req0_func),
    .req0_sel                (req0_sel),
    .req0_dst_tag            (req0_dst_tag),
    .req0_mfvr               (req0_mfvr),
    .req0_ereg               (req0_ereg),
    .req0_rdy                (req0_rdy),
    .req1_vld                (req1_vld),
    .req1_func               (req1_func),
    .req1_sel                (req1_sel),
    .req1_dst_tag            (req1_dst_tag),
    .req1_mfvr               (req1_mfvr),
    .req1_ereg               (req1_ereg),
    .req1_rdy                (req1_rdy),
    .ext_wb_resv_3           (resv),
    .dp_vfalu_ex1_pipex_func (func_o),
    .dp_vfalu_ex1_pipex_sel  (sel_o),
    .ex1_vld                 (ex1_vld),
    .ex1_owner               (ex1_owner),
    .mfvr_wb_vld             (mfvr_wb_vld),
    .mfvr_wb_tag             (mfvr_wb_tag),
    .ex3_freg_wb_vld         (ex3_freg_wb_vld),
    .ex3_freg_wb_tag         (ex3_freg_wb_tag),
    .ex3_ereg_wb_vld         (ex3_ereg_wb_vld),
    .ex3_owner               (ex3_owner),
    .pipe_busy               (pipe_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit vld;
    bit owner;
    bit mfvr;
    bit ereg;
    int tag;
    int sel;
  } op_t;

  op_t hist[$];   // op granted in each cycle (vld=0 when none)
  bit  kill[$];   // flush or reset asserted in each cycle
  int  ptr_m;
  int  last_func;
  int  n_chk;
  int  n_fail;
  int  cyc;
  bit  chk_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // An op granted in cycle g sits in stage k during cycle g+k unless killed in between.
  function automatic op_t stage_at(input int t, input int k);
    op_t e;
    e = '{default: 0};
    if (t - k < 0) return e;
    if (!hist[t-k].vld) return e;
    for (int c = t - k + 1; c < t; c++) begin
      if (kill[c]) return e;
    end
    return hist[t-k];
  endfunction

  task automatic step();
    bit  el0, el1, g0, g1;
    op_t s1, s2, s3, g;
    int  t;
    #3;
    t   = hist.size();
    el0 = req0_vld && !flush && !cpurst && (req0_mfvr || !resv);
    el1 = req1_vld && !flush && !cpurst && (req1_mfvr || !resv);
    if (el0 && el1) begin
      g0 = (ptr_m == 0);
      g1 = (ptr_m == 1);
    end else begin
      g0 = el0;
      g1 = el1;
    end
    s1 = stage_at(t, 1);
    s2 = stage_at(t, 2);
    s3 = stage_at(t, 3);
    if (chk_en) begin
      chk("req0_rdy", 32'(req0_rdy), 32'(g0));
      chk("req1_rdy", 32'(req1_rdy), 32'(g1));
      chk("ex1_vld", 32'(ex1_vld), 32'(s1.vld));
      chk("ex1_owner", 32'(ex1_owner), 32'(s1.owner));
      chk("ex1_sel", 32'(sel_o), s1.vld ? s1.sel : 0);
      chk("ex1_func", 32'(func_o), last_func);
      chk("mfvr_wb_vld", 32'(mfvr_wb_vld), 32'(s1.vld && s1.mfvr));
      chk("mfvr_wb_tag", 32'(mfvr_wb_tag), (s1.vld && s1.mfvr) ? s1.tag : 0);
      chk("freg_wb_vld", 32'(ex3_freg_wb_vld), 32'(s3.vld && !s3.mfvr));
      chk("freg_wb_tag", 32'(ex3_freg_wb_tag), (s3.vld && !s3.mfvr) ? s3.tag : 0);
      chk("ereg_wb_vld", 32'(ex3_ereg_wb_vld), 32'(s3.vld && s3.ereg));
      chk("ex3_owner", 32'(ex3_owner), 32'(s3.owner));
      chk("pipe_busy", 32'(pipe_busy), 32'(s1.vld || s2.vld || s3.vld));
    end
    g = '{default: 0};
    if (g0) begin
      g = '{vld: 1, owner: 0, mfvr: req0_mfvr, ereg: req0_ereg, tag: int'(req0_dst_tag), sel: int'(req0_sel)};
      last_func = int'(req0_func);
      ptr_m = 1;
    end else if (g1) begin
      g = '{vld: 1, owner: 1, mfvr: req1_mfvr, ereg: req1_ereg, tag: int'(req1_dst_tag), sel: int'(req1_sel)};
      last_func = int'(req1_func);
      ptr_m = 0;
    end
    if (cpurst) begin
      ptr_m = 0;
      last_func = 0;
    end
    hist.push_back(g);
    kill.push_back(flush || cpurst);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    cpurst = 0; flush = 0; resv = 0;
    req0_vld = 0; req0_mfvr = 0; req0_ereg = 0; req0_dst_tag = '0; req0_sel = '0; req0_func = '0;
    req1_vld = 0; req1_mfvr = 0; req1_ereg = 0; req1_dst_tag = '0; req1_sel = '0; req1_func = '0;
  endtask

  task automatic set_req0(input bit m, input bit e, input logic [TAG_W-1:0] tg, input logic [2:0] s);
    req0_vld = 1; req0_mfvr = m; req0_ereg = e; req0_dst_tag = tg; req0_sel = s;
    req0_func = FUNC_W'($urandom);
  endtask

  task automatic set_req1(input bit m, input bit e, input logic [TAG_W-1:0] tg, input logic [2:0] s);
    req1_vld = 1; req1_mfvr = m; req1_ereg = e; req1_dst_tag = tg; req1_sel = s;
    req1_func = FUNC_W'($urandom);
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; ptr_m = 0; last_func = 0; chk_en = 0;
    idle();
    cpurst = 1;
    @(posedge clk);
    #1;
    step();
    step();
    chk_en = 1;
    drain(2);

    // single non-mfvr issue from req0
    set_req0(0, 0, 7'h15, 3'd1); step();
    drain(4);

    // both requesters held for four cycles alternate
    for (int i = 0; i < 4; i++) begin
      set_req0(0, 0, 7'(8'h20 + i), 3'd1);
      set_req1(0, 1, 7'(8'h40 + i), 3'd2);
      step();
    end
    drain(4);

    // reservation blocks only the non-mfvr requester
    set_req0(0, 0, 7'h11, 3'd1); step();
    idle(); step();
    resv = 1;
    set_req0(0, 0, 7'h12, 3'd1);
    set_req1(1, 0, 7'h13, 3'd2);
    step();
    drain(4);

    // back-to-back issue with flush on the third cycle
    set_req0(0, 1, 7'h31, 3'd1); step();
    idle(); set_req1(0, 1, 7'h32, 3'd2); step();
    idle(); set_req0(0, 1, 7'h33, 3'd1); flush = 1; step();
    drain(3);

    // reset with ex2 valid and pointer at 1, then a tie must go to req0
    idle(); set_req0(0, 0, 7'h51, 3'd1); step();
    idle(); step();
    idle(); cpurst = 1; step();
    idle(); set_req0(0, 0, 7'h52, 3'd1); set_req1(0, 0, 7'h53, 3'd2); step();
    drain(4);

    // mfvr + ereg at max tag
    set_req1(1, 1, 7'h7F, 3'd2); step();
    drain(4);

    for (int i = 0; i < NRAND; i++) begin
      idle();
      cpurst = ($urandom_range(0, 99) < 2);
      flush  = ($urandom_range(0, 99) < 4);
      resv   = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 9) < 7)
        set_req0(1'($urandom_range(0, 9) < 3), 1'($urandom), 7'($urandom), 3'($urandom_range(1, 7)));
      if ($urandom_range(0, 9) < 7)
        set_req1(1'($urandom_range(0, 9) < 3), 1'($urandom), 7'($urandom), 3'($urandom_range(1, 7)));
      step();
    end
    drain(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
